// File: rtl/res_cmd_writer.sv
// Video-mode command producer for the ADV7513 command FIFO write port.
// Optional RES_CMD_STARTUP_SEND_EN: force a write of the first stable code after reset.
module res_cmd_writer #(
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] resolution,
    input  logic       is_240p,
    input  logic       is_480i,
    input  logic       is_576i,
    input  logic       resend,
    input  logic       wrfull,
    output logic       wrreq,
    output logic [7:0] wdata
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;

`ifdef RES_CMD_STARTUP_SEND_EN
    localparam logic FORCE_INIT = 1'b1;
`else
    localparam logic FORCE_INIT = 1'b0;
`endif

    logic [1:0]    state, state_n;
    logic [7:0]    cur_code, code;
    logic [7:0]    last_sent, last_n;
    logic [7:0]    candidate, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          force_pend, force_n;
    logic          wr_n;
    logic [7:0]    wdata_n;
    logic [2:0]    mode;
    logic          changed;
    logic          drop;

    // 576i outranks 480i, which outranks 240p
    always_comb begin
        mode = 3'b000;
        if (is_576i)
            mode = 3'b100;
        else if (is_480i)
            mode = 3'b010;
        else if (is_240p)
            mode = 3'b001;
        code = {1'b0, mode, 2'b00, resolution};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cur_code <= 8'h00;
        else
            cur_code <= code;
    end

    assign changed = (cur_code != candidate);
    assign drop    = (cur_code == last_sent) && !force_pend;

    always_comb begin
        state_n = state;
        cand_n  = candidate;
        cnt_n   = cnt;
        last_n  = last_sent;
        wr_n    = 1'b0;
        wdata_n = wdata;
        case (state)
            IDLE: begin
                if ((cur_code != last_sent) || force_pend) begin
                    cand_n  = cur_code;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (changed) begin
                    if (drop) begin
                        state_n = IDLE;
                    end else begin
                        cand_n = cur_code;
                        cnt_n  = '0;
                    end
                end else if (cnt == CNT_MAX) begin
                    state_n = WRITE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WRITE: begin
                if (changed) begin
                    if (drop) begin
                        state_n = IDLE;
                    end else begin
                        cand_n  = cur_code;
                        cnt_n   = '0;
                        state_n = SETTLE;
                    end
                end else if (!wrfull) begin
                    wr_n    = 1'b1;
                    wdata_n = candidate;
                    last_n  = candidate;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // a write consumes any pending resend, including one arriving this cycle
    always_comb begin
        if (wr_n)
            force_n = 1'b0;
        else if (resend)
            force_n = 1'b1;
        else
            force_n = force_pend;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            candidate  <= 8'h00;
            cnt        <= '0;
            last_sent  <= 8'h00;
            force_pend <= FORCE_INIT;
            wrreq      <= 1'b0;
            wdata      <= 8'h00;
        end else begin
            state      <= state_n;
            candidate  <= cand_n;
            cnt        <= cnt_n;
            last_sent  <= last_n;
            force_pend <= force_n;
            wrreq      <= wr_n;
            wdata      <= wdata_n;
        end
    end

endmodule

// File: tb/tb_res_cmd_writer.sv
// Randomized and directed bench for res_cmd_writer against a run-length model.
module tb_res_cmd_writer;

    localparam int SC = 4;

`ifdef RES_CMD_STARTUP_SEND_EN
    localparam int STARTUP = 1;
`else
    localparam int STARTUP = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] resolution = 2'd0;
    logic       is_240p = 1'b0;
    logic       is_480i = 1'b0;
    logic       is_576i = 1'b0;
    logic       resend = 1'b0;
    logic       wrfull = 1'b0;
    logic       wrreq;
    logic [7:0] wdata;

    res_cmd_writer #(.STABLE_CYCLES(SC)) dut (
        .clock      (clock),
        .reset      (reset),
        .resolution (resolution),
        .is_240p    (is_240p),
        .is_480i    (is_480i),
        .is_576i    (is_576i),
        .resend     (resend),
        .wrfull     (wrfull),
        .wrreq      (wrreq),
        .wdata      (wdata)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a pending code is written once it has been seen SC+2 edges in a row
    logic [7:0] m_cur, m_last, m_cand, m_wdata;
    logic       m_pend, m_force, m_wr;
    int         m_age;

    int         cyc = 0;
    int         n_wr = 0;
    int         wr_cyc = 0;
    logic [7:0] wr_data = 8'h00;

    function automatic logic [7:0] code_of(input logic [1:0] r, input logic a240,
                                           input logic a480, input logic a576);
        logic [7:0] cls;
        cls = a576 ? 8'h40 : a480 ? 8'h20 : a240 ? 8'h10 : 8'h00;
        return cls | {6'd0, r};
    endfunction

    task automatic model_reset();
        m_cur   = 8'h00;
        m_last  = 8'h00;
        m_cand  = 8'h00;
        m_wdata = 8'h00;
        m_pend  = 1'b0;
        m_force = (STARTUP != 0);
        m_wr    = 1'b0;
        m_age   = 0;
    endtask

    task automatic step();
        logic [7:0] nxt;
        logic       wr;
        nxt = code_of(resolution, is_240p, is_480i, is_576i);
        wr  = 1'b0;
        if (!m_pend) begin
            if (m_cur != m_last || m_force) begin
                m_pend = 1'b1;
                m_cand = m_cur;
                m_age  = 1;
            end
        end else if (m_cur != m_cand) begin
            if (m_cur == m_last && !m_force) begin
                m_pend = 1'b0;
            end else begin
                m_cand = m_cur;
                m_age  = 1;
            end
        end else begin
            m_age++;
            if (m_age >= SC + 2 && !wrfull) begin
                wr      = 1'b1;
                m_last  = m_cand;
                m_wdata = m_cand;
                m_pend  = 1'b0;
            end
        end
        m_force = wr ? 1'b0 : (resend ? 1'b1 : m_force);
        m_wr    = wr;
        m_cur   = nxt;
        @(posedge clock);
        #1;
        cyc++;
        check("wrreq", {31'd0, wrreq}, {31'd0, m_wr});
        check("wdata", {24'd0, wdata}, {24'd0, m_wdata});
        if (wrreq) begin
            n_wr++;
            wr_cyc  = cyc;
            wr_data = wdata;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic set_code(input logic [1:0] r, input logic a240,
                            input logic a480, input logic a576);
        resolution = r;
        is_240p    = a240;
        is_480i    = a480;
        is_576i    = a576;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_wrreq", {31'd0, wrreq}, 32'd0);
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        model_reset();
        #2;
        do_reset();

        n_wr = 0;
        run(50);
        check("startup_writes", n_wr, STARTUP);
        if (STARTUP != 0)
            check("startup_data", {24'd0, wr_data}, 32'h00);

        n_wr = 0;
        set_code(2'd3, 1'b1, 1'b0, 1'b0);
        c0 = cyc;
        run(20);
        check("vga240_writes", n_wr, 1);
        check("vga240_data", {24'd0, wr_data}, 32'h13);
        check("vga240_latency", wr_cyc - c0, SC + 3);

        n_wr = 0;
        set_code(2'd1, 1'b0, 1'b1, 1'b1);
        run(20);
        check("prio_writes", n_wr, 1);
        check("prio_data", {24'd0, wr_data}, 32'h41);

        set_code(2'd0, 1'b0, 1'b0, 1'b0);
        run(20);
        n_wr = 0;
        set_code(2'd2, 1'b0, 1'b0, 1'b0);
        run(2);
        set_code(2'd0, 1'b0, 1'b0, 1'b0);
        run(20);
        check("glitch_back", n_wr, 0);

        set_code(2'd2, 1'b0, 1'b0, 1'b0);
        run(2);
        set_code(2'd3, 1'b0, 1'b0, 1'b0);
        run(20);
        check("glitch_fwd_writes", n_wr, 1);
        check("glitch_fwd_data", {24'd0, wr_data}, 32'h03);

        n_wr = 0;
        wrfull = 1'b1;
        set_code(2'd2, 1'b0, 1'b1, 1'b0);
        run(SC + 2 + 10);
        check("stall_writes", n_wr, 0);
        wrfull = 1'b0;
        run(1);
        check("stall_release", n_wr, 1);
        check("stall_data", {24'd0, wr_data}, 32'h22);
        run(10);
        check("stall_single", n_wr, 1);

        set_code(2'd2, 1'b1, 1'b0, 1'b0);
        run(20);
        n_wr = 0;
        resend = 1'b1;
        step();
        resend = 1'b0;
        run(20);
        check("resend_writes", n_wr, 1);
        check("resend_data", {24'd0, wr_data}, 32'h12);

        wrfull = 1'b1;
        set_code(2'd1, 1'b0, 1'b0, 1'b0);
        run(12);
        set_code(2'd0, 1'b0, 1'b0, 1'b0);
        wrfull = 1'b0;
        do_reset();
        n_wr = 0;
        run(30);
        check("post_reset_writes", n_wr, STARTUP);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 8 == 0)
                set_code(2'($urandom), 1'($urandom), ($urandom % 3 == 0),
                         ($urandom % 4 == 0));
            wrfull = ($urandom % 4 == 0);
            resend = ($urandom % 32 == 0);
            if ($urandom % 700 == 0) begin
                resend = 1'b0;
                do_reset();
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
